// File: rtl/pellet_tracker.sv
// Pellet grid for the pacman playfield: one bit per 16x16 tile, cleared when pacman walks over it.
// Tracks score and remaining pellets, and offers an independent read port to the colour mapper.
module pellet_tracker #(
  parameter int TILE_SHIFT    = 4,
  parameter int COLS          = 40,
  parameter int ROWS          = 30,
  parameter int PELLET_POINTS = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic        hasMoved,
  input  logic        death,
  input  logic        level_restart,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        pellet_here,
  output logic [15:0] score,
  output logic [10:0] pellets_left,
  output logic        eat_pulse,
  output logic        level_clear,
  output logic        busy
);

  localparam int NUM_TILES = COLS * ROWS;
  localparam int ADDR_W    = $clog2(NUM_TILES);
  localparam int TC_W      = 10 - TILE_SHIFT;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_TILES - 1);
  localparam logic [10:0]       FULL_COUNT = 11'(NUM_TILES);
  localparam logic [15:0]       POINTS     = 16'(PELLET_POINTS);

  typedef enum logic [1:0] {INIT, PLAY, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] sweep_reg, sweep_next;
  logic [15:0]       score_reg, score_next;
  logic [10:0]       pellets_left_reg, pellets_left_next;
  logic              eat_pulse_reg;
  logic              s1_valid_reg, s1_valid_next;
  logic [ADDR_W-1:0] s1_addr_reg;
  logic              eat_q_reg;
  logic              hit_reg;
  logic              render_q_reg;
  logic              render_en_reg;

  logic              s1_bit;
  logic              eat_now;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_wdata;
  logic              ram [NUM_TILES];

  // Port 0 maps pacman's position, port 1 maps the render pixel.
  logic [9:0]        map_x [2];
  logic [9:0]        map_y [2];
  logic              on_grid [2];
  logic [ADDR_W-1:0] tile_addr [2];

  assign map_x[0] = BallX;
  assign map_y[0] = BallY;
  assign map_x[1] = DrawX;
  assign map_y[1] = DrawY;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_map
      logic [TC_W-1:0] col;
      logic [TC_W-1:0] row;
      assign col           = TC_W'(map_x[gi] >> TILE_SHIFT);
      assign row           = TC_W'(map_y[gi] >> TILE_SHIFT);
      assign on_grid[gi]   = (int'(col) < COLS) && (int'(row) < ROWS);
      assign tile_addr[gi] = on_grid[gi] ? (ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col)) : '0;
    end
  endgenerate

  // A read that lands on the tile being cleared this same edge must see it empty.
  assign s1_bit  = eat_q_reg & ~hit_reg;
  assign eat_now = (state_reg == PLAY) && s1_valid_reg && s1_bit;

  always_comb begin
    state_next        = state_reg;
    sweep_next        = sweep_reg;
    score_next        = score_reg;
    pellets_left_next = pellets_left_reg;
    s1_valid_next     = (state_reg == PLAY) && hasMoved && !death && on_grid[0];
    ram_we            = 1'b0;
    ram_waddr         = s1_addr_reg;
    ram_wdata         = 1'b0;

    case (state_reg)
      INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = sweep_reg;
        ram_wdata  = 1'b1;
        sweep_next = sweep_reg + ADDR_W'(1);
        if (sweep_reg == LAST_ADDR) begin
          sweep_next        = '0;
          pellets_left_next = FULL_COUNT;
          state_next        = PLAY;
        end
      end
      PLAY: begin
        if (pellets_left_reg == 11'd0) state_next = CLEAR;
      end
      CLEAR: ;
      default: state_next = INIT;
    endcase

    if (eat_now) begin
      ram_we     = 1'b1;
      ram_waddr  = s1_addr_reg;
      ram_wdata  = 1'b0;
      score_next = (score_reg > (16'hFFFF - POINTS)) ? 16'hFFFF : (score_reg + POINTS);
      if (pellets_left_reg != 11'd0) pellets_left_next = pellets_left_reg - 11'd1;
    end

    if (level_restart) begin
      state_next = INIT;
      sweep_next = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    eat_q_reg    <= ram[tile_addr[0]];
    render_q_reg <= ram[tile_addr[1]];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg        <= INIT;
      sweep_reg        <= '0;
      score_reg        <= '0;
      pellets_left_reg <= '0;
      eat_pulse_reg    <= 1'b0;
      s1_valid_reg     <= 1'b0;
      s1_addr_reg      <= '0;
      hit_reg          <= 1'b0;
      render_en_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sweep_reg        <= sweep_next;
      score_reg        <= score_next;
      pellets_left_reg <= pellets_left_next;
      eat_pulse_reg    <= eat_now;
      s1_valid_reg     <= s1_valid_next;
      s1_addr_reg      <= tile_addr[0];
      hit_reg          <= eat_now && (s1_addr_reg == tile_addr[0]);
      render_en_reg    <= (state_reg != INIT) && on_grid[1];
    end
  end

  assign pellet_here  = render_q_reg & render_en_reg;
  assign score        = score_reg;
  assign pellets_left = pellets_left_reg;
  assign eat_pulse    = eat_pulse_reg;
  assign level_clear  = (state_reg == CLEAR);
  assign busy         = (state_reg == INIT);

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker: literal checks per scenario plus a tile-level
// game model compared against every output on every cycle after the first reset.
module tb_pellet_tracker;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  BallX = '0;
  logic [9:0]  BallY = '0;
  logic        hasMoved = 1'b0;
  logic        death = 1'b0;
  logic        level_restart = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        pellet_here;
  logic [15:0] score;
  logic [10:0] pellets_left;
  logic        eat_pulse;
  logic        level_clear;
  logic        busy;

  pellet_tracker dut (
    .Clk          (clk),
    .Reset        (Reset),
    .BallX        (BallX),
    .BallY        (BallY),
    .hasMoved     (hasMoved),
    .death        (death),
    .level_restart(level_restart),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .pellet_here  (pellet_here),
    .score        (score),
    .pellets_left (pellets_left),
    .eat_pulse    (eat_pulse),
    .level_clear  (level_clear),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  bit draw_hold = 0;

  task automatic chk(input string name, input int got, input int exp, input bit verbose);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end else if (verbose) begin
      $display("txn %s: got=%0d expected=%0d ok", name, got, exp);
    end
  endtask

  // ---------------- game model ----------------
  localparam int M_INIT = 0, M_PLAY = 1, M_CLEAR = 2;
  localparam int N_TILES = 1200;
  bit m_pellet [N_TILES];
  int m_mode = M_INIT;
  int m_cnt = 0;
  int m_score = 0;
  int m_left = 0;
  bit m_pulse = 0;
  bit m_render = 0;
  bit m_pend = 0;
  int m_pend_tile = 0;
  bit model_on = 0;

  task automatic model_step();
    int bc, br, dc, dr, old_mode, left_pre;
    bit b_on, d_on;
    bc = int'(BallX) / 16;  br = int'(BallY) / 16;
    dc = int'(DrawX) / 16;  dr = int'(DrawY) / 16;
    b_on = (bc < 40) && (br < 30);
    d_on = (dc < 40) && (dr < 30);
    if (Reset) begin
      m_mode = M_INIT; m_cnt = 0; m_score = 0; m_left = 0;
      m_pulse = 0; m_pend = 0; m_render = 0; model_on = 1;
    end else begin
      old_mode = m_mode;
      left_pre = m_left;
      m_render = (old_mode != M_INIT && d_on) ? m_pellet[dr*40 + dc] : 1'b0;
      m_pulse = 0;
      if (old_mode == M_PLAY && m_pend && m_pellet[m_pend_tile]) begin
        m_pellet[m_pend_tile] = 0;
        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        if (m_left > 0) m_left--;
        m_pulse = 1;
      end
      m_pend = (old_mode == M_PLAY) && hasMoved && !death && b_on;
      m_pend_tile = b_on ? br*40 + bc : 0;
      if (old_mode == M_INIT) begin
        m_cnt++;
        if (m_cnt == N_TILES) begin
          for (int i = 0; i < N_TILES; i++) m_pellet[i] = 1;
          m_left = N_TILES;
          m_mode = M_PLAY;
        end
      end else if (old_mode == M_PLAY && left_pre == 0) begin
        m_mode = M_CLEAR;
      end
      if (level_restart) begin
        m_mode = M_INIT;
        m_cnt = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("m_busy",        int'(busy),         int'(m_mode == M_INIT),  0);
      chk("m_level_clear", int'(level_clear),  int'(m_mode == M_CLEAR), 0);
      chk("m_score",       int'(score),        m_score,                 0);
      chk("m_pellets",     int'(pellets_left), m_left,                  0);
      chk("m_eat_pulse",   int'(eat_pulse),    int'(m_pulse),           0);
      chk("m_pellet_here", int'(pellet_here),  int'(m_render),          0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    int dx, dy;
    @(negedge clk);
    pulse_cnt += int'(eat_pulse);
    if (!draw_hold) begin
      dx = (int'(DrawX) + 13) % 720;
      dy = (int'(DrawY) + 7) % 520;
      DrawX = 10'(dx);
      DrawY = 10'(dy);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      n++;
      step();
    end
    chk(name, n, 1200, 1);
  endtask

  task automatic eat_all();
    hasMoved = 1;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) begin
        BallX = 10'(c*16 + 8);
        BallY = 10'(r*16 + 8);
        step();
      end
    hasMoved = 0;
    steps(4);
  endtask

  initial begin
    // Reset and first fill
    step();
    Reset = 0;
    chk("reset_score", int'(score), 0, 1);
    chk("reset_pellet_here", int'(pellet_here), 0, 1);
    count_busy("init_busy_cycles");
    chk("init_left", int'(pellets_left), 1200, 1);
    chk("init_score", int'(score), 0, 1);

    // Sit on tile (1,1) for 10 cycles
    BallX = 24; BallY = 24; hasMoved = 1; pulse_cnt = 0;
    step(); chk("eat_lat_cycle1", int'(eat_pulse), 0, 1);
    step(); chk("eat_lat_cycle2", int'(eat_pulse), 1, 1);
    steps(8);
    chk("eat_once", pulse_cnt, 1, 1);
    chk("eat_score", int'(score), 10, 1);
    chk("eat_left", int'(pellets_left), 1199, 1);
    draw_hold = 1; DrawX = 20; DrawY = 20;
    step(); chk("render_eaten", int'(pellet_here), 0, 1);
    DrawX = 40;
    step(); chk("render_full", int'(pellet_here), 1, 1);
    DrawX = 700;
    step(); chk("render_offgrid", int'(pellet_here), 0, 1);
    draw_hold = 0;

    // Spawn tile is not eaten until pacman has moved
    hasMoved = 0; BallX = 304; BallY = 240; pulse_cnt = 0;
    steps(6); chk("spawn_no_eat", pulse_cnt, 0, 1);
    hasMoved = 1;
    steps(6); chk("spawn_eat_once", pulse_cnt, 1, 1);
    chk("spawn_score", int'(score), 20, 1);
    chk("spawn_left", int'(pellets_left), 1198, 1);

    // Sweep row 0 pixel by pixel, then off-grid positions
    BallY = 8; pulse_cnt = 0;
    for (int x = 0; x < 640; x++) begin
      BallX = 10'(x);
      step();
    end
    steps(3);
    chk("row_pulses", pulse_cnt, 40, 1);
    chk("row_score", int'(score), 420, 1);
    BallX = 700; pulse_cnt = 0;
    steps(5); chk("offgrid_x", pulse_cnt, 0, 1);
    BallX = 200; BallY = 500;
    steps(5); chk("offgrid_y", pulse_cnt, 0, 1);

    // death stalls new samples but lets the in-flight one finish
    BallX = 88; BallY = 88; pulse_cnt = 0;
    step();
    death = 1; BallX = 104;
    steps(6); chk("death_inflight", pulse_cnt, 1, 1);
    death = 0;
    steps(4); chk("death_release", pulse_cnt, 2, 1);
    chk("death_left", int'(pellets_left), 1156, 1);

    // Clear the level
    eat_all();
    chk("clear_flag", int'(level_clear), 1, 1);
    chk("clear_score", int'(score), 12000, 1);
    chk("clear_left", int'(pellets_left), 0, 1);

    // Restart keeps score
    level_restart = 1; step(); level_restart = 0;
    chk("restart_busy", int'(busy), 1, 1);
    chk("restart_score", int'(score), 12000, 1);
    count_busy("restart_busy_cycles");
    chk("restart_left", int'(pellets_left), 1200, 1);
    chk("restart_score_kept", int'(score), 12000, 1);

    // Five more levels push the score past 16 bits
    for (int lv = 0; lv < 5; lv++) begin
      eat_all();
      level_restart = 1; step(); level_restart = 0;
      count_busy("level_busy_cycles");
    end
    chk("score_saturated", int'(score), 65535, 1);

    // Reset during the fill restarts the sweep and clears score
    level_restart = 1; step(); level_restart = 0;
    steps(500);
    Reset = 1; step(); Reset = 0;
    chk("midinit_score", int'(score), 0, 1);
    count_busy("midinit_busy_cycles");
    chk("midinit_left", int'(pellets_left), 1200, 1);
    steps(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
